// File: rtl/mem_stage_pkg.sv
// Shared definitions for the WISC-SP13 memory-stage controller:
// FSM state encoding, default access timeout and MEM/WB field widths.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    HALTED = 3'd3,
    ERROR  = 3'd4
  } memStage_e;

  localparam int DEFAULT_TIMEOUT_CYC = 15;
  localparam int WB_DATA_W           = 16;
  localparam int WB_REG_W            = 3;
  localparam int CNT_W               = 8;

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register. Loads every cycle: either the real
// instruction record or a bubble. The error flag is sticky until reset.
module memwb_reg
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bubble,
  input  logic                 errSet,
  input  logic [WB_DATA_W-1:0] wbData,
  input  logic [WB_REG_W-1:0]  wr,
  input  logic                 writeToReg,
  input  logic                 halt,
  output logic [WB_DATA_W-1:0] wbDataQ,
  output logic [WB_REG_W-1:0]  wrQ,
  output logic                 writeToRegQ,
  output logic                 haltQ,
  output logic                 validQ,
  output logic                 errQ
);

  // Capture the instruction record, or a cleared bubble when stalled/faulted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbDataQ     <= '0;
      wrQ         <= '0;
      writeToRegQ <= 1'b0;
      haltQ       <= 1'b0;
      validQ      <= 1'b0;
    end else if (bubble) begin
      wbDataQ     <= '0;
      wrQ         <= '0;
      writeToRegQ <= 1'b0;
      haltQ       <= 1'b0;
      validQ      <= 1'b0;
    end else begin
      wbDataQ     <= wbData;
      wrQ         <= wr;
      writeToRegQ <= writeToReg;
      haltQ       <= halt;
      validQ      <= 1'b1;
    end
  end

  // Sticky memory error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errQ <= 1'b0;
    end else if (errSet) begin
      errQ <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences the handshaked data memory for the
// instruction in EX/MEM, stalls the front of the pipe while an access is
// outstanding and feeds the MEM/WB register.
// Optional build macro: MEMSTG_ALIGN_CHECK_EN rejects odd memory addresses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access outstanding; memory op issues in the same cycle
// ISSUE  | request held until the memory is not busy
// WAIT   | request accepted, waiting for mem_done (with timeout)
// HALTED | halt reached writeback; absorbing until reset
// ERROR  | illegal op, misalignment or timeout; absorbing until reset
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadEn_In_FromX,
  input  logic        MemWriteEn_In_FromX,
  input  logic        RegWriteDataSel_In_FromX,
  input  logic [15:0] ALUResult_FromX,
  input  logic [15:0] RD2_In_FromX,
  input  logic [2:0]  WR_In_FromX,
  input  logic        WriteToReg_FromX,
  input  logic        Halt_In_FromX,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        Stall_Out,
  output logic [15:0] WBData_ToWB,
  output logic [2:0]  WR_ToWB,
  output logic        WriteToReg_ToWB,
  output logic        Halt_ToWB,
  output logic        Valid_ToWB,
  output logic        Err_ToWB
);

  memStage_e            state, nextState;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic                 memOp, badOp, misaligned;
  logic                 reqComb, stallComb, bubble, errSet;
  logic [WB_DATA_W-1:0] wbDataIn;
  logic                 timeoutHit;

`ifdef MEMSTG_ALIGN_CHECK_EN
  assign misaligned = ALUResult_FromX[0];
`else
  assign misaligned = 1'b0;
`endif

  assign memOp      = MemReadEn_In_FromX | MemWriteEn_In_FromX;
  assign badOp      = (MemReadEn_In_FromX & MemWriteEn_In_FromX) | misaligned;
  assign timeoutHit = ({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT_CYC);

  // State and WAIT counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  // Next-state, request, stall and MEM/WB load control.
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    reqComb   = 1'b0;
    stallComb = 1'b0;
    bubble    = 1'b1;
    errSet    = 1'b0;
    wbDataIn  = ALUResult_FromX;
    unique case (state)
      IDLE: begin
        if (memOp) begin
          stallComb = 1'b1;
          if (badOp) begin
            errSet    = 1'b1;
            nextState = ERROR;
          end else begin
            // Behave as ISSUE in this same cycle.
            reqComb = 1'b1;
            if (!mem_busy) begin
              nextState = WAIT;
              cntNext   = '0;
            end else begin
              nextState = ISSUE;
            end
          end
        end else begin
          bubble = 1'b0;
          if (Halt_In_FromX) nextState = HALTED;
        end
      end
      ISSUE: begin
        reqComb   = 1'b1;
        stallComb = 1'b1;
        if (!mem_busy) begin
          nextState = WAIT;
          cntNext   = '0;
        end
      end
      WAIT: begin
        if (mem_done) begin
          bubble    = 1'b0;
          wbDataIn  = RegWriteDataSel_In_FromX ? mem_rdata : ALUResult_FromX;
          nextState = Halt_In_FromX ? HALTED : IDLE;
        end else begin
          stallComb = 1'b1;
          if (timeoutHit) begin
            errSet    = 1'b1;
            nextState = ERROR;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cntNext = cnt + 1'b1;
          end
        end
      end
      HALTED, ERROR: begin
        stallComb = 1'b1;
      end
      default: begin
        stallComb = 1'b1;
        nextState = ERROR;
      end
    endcase
  end

  // Request and stall drop immediately with reset, abandoning any access.
  assign mem_req   = reqComb & ~rst;
  assign mem_wr    = mem_req & MemWriteEn_In_FromX;
  assign mem_addr  = mem_req ? ALUResult_FromX : 16'h0000;
  assign mem_wdata = mem_req ? RD2_In_FromX : 16'h0000;
  assign Stall_Out = stallComb & ~rst;

  memwb_reg uMemWb (
    .clk         (clk),
    .rst         (rst),
    .bubble      (bubble),
    .errSet      (errSet),
    .wbData      (wbDataIn),
    .wr          (WR_In_FromX),
    .writeToReg  (WriteToReg_FromX),
    .halt        (Halt_In_FromX),
    .wbDataQ     (WBData_ToWB),
    .wrQ         (WR_ToWB),
    .writeToRegQ (WriteToReg_ToWB),
    .haltQ       (Halt_ToWB),
    .validQ      (Valid_ToWB),
    .errQ        (Err_ToWB)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: vector table for ALU pass-through, directed
// memory/corner sequences and a randomized instruction stream checked
// against a per-instruction latency/result model.
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  logic        clk, rst;
  logic        MemReadEn_In_FromX, MemWriteEn_In_FromX, RegWriteDataSel_In_FromX;
  logic [15:0] ALUResult_FromX, RD2_In_FromX;
  logic [2:0]  WR_In_FromX;
  logic        WriteToReg_FromX, Halt_In_FromX;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_busy, mem_done;
  logic [15:0] mem_rdata;
  logic        Stall_Out;
  logic [15:0] WBData_ToWB;
  logic [2:0]  WR_ToWB;
  logic        WriteToReg_ToWB, Halt_ToWB, Valid_ToWB, Err_ToWB;

  int total  = 0;
  int passed = 0;

  mem_stage_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .MemReadEn_In_FromX(MemReadEn_In_FromX),
    .MemWriteEn_In_FromX(MemWriteEn_In_FromX),
    .RegWriteDataSel_In_FromX(RegWriteDataSel_In_FromX),
    .ALUResult_FromX(ALUResult_FromX),
    .RD2_In_FromX(RD2_In_FromX),
    .WR_In_FromX(WR_In_FromX),
    .WriteToReg_FromX(WriteToReg_FromX),
    .Halt_In_FromX(Halt_In_FromX),
    .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .Stall_Out(Stall_Out),
    .WBData_ToWB(WBData_ToWB), .WR_ToWB(WR_ToWB),
    .WriteToReg_ToWB(WriteToReg_ToWB), .Halt_ToWB(Halt_ToWB),
    .Valid_ToWB(Valid_ToWB), .Err_ToWB(Err_ToWB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] alu;
    logic [2:0]  wr;
    logic        wtr;
    logic        sel;
    logic [15:0] expData;
    logic [2:0]  expWr;
    logic        expWtr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic setEx(input logic rd, input logic wrEn, input logic sel,
                       input logic [15:0] alu, input logic [15:0] rd2,
                       input logic [2:0] wrReg, input logic wtr, input logic halt);
    MemReadEn_In_FromX       = rd;
    MemWriteEn_In_FromX      = wrEn;
    RegWriteDataSel_In_FromX = sel;
    ALUResult_FromX          = alu;
    RD2_In_FromX             = rd2;
    WR_In_FromX              = wrReg;
    WriteToReg_FromX         = wtr;
    Halt_In_FromX            = halt;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    setEx(0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 0);
    mem_busy = 0; mem_done = 0;
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Drives one instruction through EX/MEM (starting at posedge+1) until the
  // controller releases it; memory responds busyN cycles busy, then mem_done
  // lat cycles after acceptance. Expected cycle/request/stall counts and the
  // writeback record follow directly from the handshake rules.
  task automatic runInstr(input string tag, input logic rd, input logic wrEn, input logic sel,
                          input logic [15:0] alu, input logic [15:0] rd2,
                          input logic [2:0] wrReg, input logic wtr,
                          input int busyN, input int lat, input logic [15:0] rdata,
                          input bit spur);
    logic        isMem;
    logic [15:0] expData;
    int          cyc, reqs, stalls;
    bit          leave;
    isMem   = rd | wrEn;
    expData = (isMem && sel) ? rdata : alu;
    setEx(rd, wrEn, sel, alu, rd2, wrReg, wtr, 0);
    cyc = 0; reqs = 0; stalls = 0; leave = 0;
    while (!leave && cyc < 60) begin
      if (isMem) begin
        mem_busy  = (cyc < busyN);
        mem_done  = (cyc == busyN + lat) ? 1'b1
                  : ((spur && cyc <= busyN) ? 1'($urandom_range(0, 1)) : 1'b0);
        mem_rdata = (cyc == busyN + lat) ? rdata : 16'($urandom);
      end else begin
        mem_busy  = 1'($urandom_range(0, 1));
        mem_done  = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = 16'($urandom);
      end
      @(negedge clk);
      if (mem_req) begin
        reqs++;
        check({tag, " addr"}, mem_addr, alu);
        check({tag, " wr"}, mem_wr, wrEn);
        check({tag, " wdata"}, mem_wdata, rd2);
      end
      if (cyc >= 1) check({tag, " bubble valid"}, Valid_ToWB, 0);
      if (Stall_Out) stalls++;
      else leave = 1;
      nextCycle();
      cyc++;
    end
    mem_busy = 0; mem_done = 0;
    check({tag, " cycles"}, cyc, isMem ? busyN + lat + 1 : 1);
    check({tag, " reqs"}, reqs, isMem ? busyN + 1 : 0);
    check({tag, " stalls"}, stalls, isMem ? busyN + lat : 0);
    check({tag, " wbdata"}, WBData_ToWB, expData);
    check({tag, " wr"}, WR_ToWB, wrReg);
    check({tag, " wtr"}, WriteToReg_ToWB, wtr);
    check({tag, " valid"}, Valid_ToWB, 1);
    check({tag, " err"}, Err_ToWB, 0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 3'd3, 1'b1, 1'b0, 16'h1234, 3'd3, 1'b1};
    vecs[1] = '{16'h0000, 3'd0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1};
    vecs[2] = '{16'hFFFF, 3'd7, 1'b0, 1'b0, 16'hFFFF, 3'd7, 1'b0};
    vecs[3] = '{16'h8001, 3'd5, 1'b1, 1'b1, 16'h8001, 3'd5, 1'b1};
    vecs[4] = '{16'h0041, 3'd1, 1'b0, 1'b1, 16'h0041, 3'd1, 1'b0};

    // Reset values, with a load presented during reset.
    rst = 1'b1;
    mem_busy = 0; mem_done = 0; mem_rdata = 16'h0;
    setEx(1, 0, 1, 16'h0040, 16'h1111, 3'd2, 1, 0);
    @(negedge clk);
    check("rst mem_req", mem_req, 0);
    check("rst stall", Stall_Out, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wr", mem_wr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst wbdata", WBData_ToWB, 0);
    check("rst valid", Valid_ToWB, 0);
    check("rst wtr", WriteToReg_ToWB, 0);
    check("rst halt", Halt_ToWB, 0);
    check("rst err", Err_ToWB, 0);
    doReset();

    // ALU pass-through vectors.
    for (int i = 0; i < 5; i++) begin
      setEx(0, 0, vecs[i].sel, vecs[i].alu, 16'hA5A5, vecs[i].wr, vecs[i].wtr, 0);
      mem_done = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d stall", i), Stall_Out, 0);
      check($sformatf("vec%0d req", i), mem_req, 0);
      nextCycle();
      check($sformatf("vec%0d wbdata", i), WBData_ToWB, vecs[i].expData);
      check($sformatf("vec%0d wr", i), WR_ToWB, vecs[i].expWr);
      check($sformatf("vec%0d wtr", i), WriteToReg_ToWB, vecs[i].expWtr);
      check($sformatf("vec%0d valid", i), Valid_ToWB, 1);
    end
    mem_done = 0;

    // Directed memory accesses.
    runInstr("load40", 1, 0, 1, 16'h0040, 16'h0000, 3'd4, 1, 0, 2, 16'hBEEF, 0);
    runInstr("store10", 0, 1, 0, 16'h0010, 16'h00FF, 3'd0, 0, 3, 1, 16'h0000, 0);
    runInstr("loadTmoEdge", 1, 0, 1, 16'h0080, 16'h0000, 3'd6, 1, 1, TMO, 16'hC0DE, 1);
    runInstr("loadSel0", 1, 0, 0, 16'h0022, 16'h0000, 3'd2, 1, 0, 1, 16'h9999, 0);

    // Random instruction stream.
    for (int n = 0; n < 40; n++) begin
      int          kind;
      logic [15:0] a;
      kind = $urandom_range(0, 2);
      a    = 16'($urandom);
      if (kind == 0)
        runInstr($sformatf("rnd%0d alu", n), 0, 0, 1'($urandom_range(0, 1)), a,
                 16'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), 0, 1, 16'h0, 1);
      else if (kind == 1)
        runInstr($sformatf("rnd%0d ld", n), 1, 0, 1'($urandom_range(0, 1)), a & 16'hFFFE,
                 16'($urandom), 3'($urandom), 1, $urandom_range(0, 3), $urandom_range(1, TMO),
                 16'($urandom), 1);
      else
        runInstr($sformatf("rnd%0d st", n), 0, 1, 0, a & 16'hFFFE,
                 16'($urandom), 3'($urandom), 0, $urandom_range(0, 3), $urandom_range(1, TMO),
                 16'($urandom), 1);
    end

    // Odd address load.
`ifdef MEMSTG_ALIGN_CHECK_EN
    setEx(1, 0, 1, 16'h0041, 16'h0, 3'd1, 1, 0);
    @(negedge clk);
    check("align req", mem_req, 0);
    check("align stall", Stall_Out, 1);
    nextCycle();
    check("align err", Err_ToWB, 1);
    check("align valid", Valid_ToWB, 0);
    doReset();
`else
    runInstr("load41", 1, 0, 1, 16'h0041, 16'h0, 3'd1, 1, 0, 2, 16'h5A5A, 0);
`endif

    // Reset in the middle of a busy request.
    setEx(0, 1, 0, 16'h0100, 16'h7777, 3'd0, 0, 0);
    mem_busy = 1;
    @(negedge clk);
    check("midrst req before", mem_req, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst req async", mem_req, 0);
    check("midrst stall async", Stall_Out, 0);
    doReset();
    runInstr("postrst alu", 0, 0, 0, 16'h4321, 16'h0, 3'd5, 1, 0, 1, 16'h0, 0);

    // Halt, then a load that must not issue.
    setEx(0, 0, 0, 16'h0000, 16'h0, 3'd0, 0, 1);
    @(negedge clk);
    check("halt stall", Stall_Out, 0);
    nextCycle();
    check("halt towb", Halt_ToWB, 1);
    check("halt valid", Valid_ToWB, 1);
    setEx(1, 0, 1, 16'h0020, 16'h0, 3'd2, 1, 0);
    @(negedge clk);
    check("halted req", mem_req, 0);
    check("halted stall", Stall_Out, 1);
    nextCycle();
    nextCycle();
    check("halted valid", Valid_ToWB, 0);
    check("halted stall hold", Stall_Out, 1);
    doReset();

    // Read and write together.
    setEx(1, 1, 1, 16'h0050, 16'h1234, 3'd3, 1, 0);
    @(negedge clk);
    check("rdwr req", mem_req, 0);
    check("rdwr stall", Stall_Out, 1);
    nextCycle();
    check("rdwr err", Err_ToWB, 1);
    check("rdwr valid", Valid_ToWB, 0);
    check("rdwr wtr", WriteToReg_ToWB, 0);
    doReset();
    check("rdwr err cleared", Err_ToWB, 0);

    // Timeout: no mem_done ever.
    setEx(1, 0, 1, 16'h0030, 16'h0, 3'd7, 1, 0);
    for (int k = 0; k < TMO; k++) nextCycle();
    @(negedge clk);
    check("tmo req in wait", mem_req, 0);
    check("tmo stall in wait", Stall_Out, 1);
    check("tmo err early", Err_ToWB, 0);
    nextCycle();
    check("tmo err", Err_ToWB, 1);
    check("tmo valid", Valid_ToWB, 0);
    mem_done = 1; mem_rdata = 16'hDEAD;
    nextCycle();
    mem_done = 0;
    nextCycle();
    @(negedge clk);
    check("tmo stuck stall", Stall_Out, 1);
    check("tmo stuck req", mem_req, 0);
    check("tmo stuck valid", Valid_ToWB, 0);
    check("tmo stuck err", Err_ToWB, 1);
    doReset();
    @(negedge clk);
    check("tmo rst err", Err_ToWB, 0);
    check("tmo rst stall", Stall_Out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the five-stage WISC-SP13 pipeline. It consumes the EX/MEM pipeline register outputs and drives a multicycle, handshaked data memory. It stalls the front of the pipeline while an access is outstanding and produces the registered MEM/WB bundle for writeback. It is the reading end of the EX/MEM interface and owns all data-memory sequencing.

## Interface
Parameters:
- TIMEOUT_CYC, 15: maximum cycles in WAIT before the access is declared failed; range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- MemReadEn_In_FromX  in  1  load in EX/MEM
- MemWriteEn_In_FromX  in  1  store in EX/MEM
- RegWriteDataSel_In_FromX  in  1  1 = writeback memory data, 0 = writeback ALU result
- ALUResult_FromX  in  16  memory address or ALU result
- RD2_In_FromX  in  16  store data
- WR_In_FromX  in  3  destination register
- WriteToReg_FromX  in  1  register write enable
- Halt_In_FromX  in  1  halt instruction
- mem_req  out  1  access request
- mem_wr  out  1  1 = write
- mem_addr  out  16  access address
- mem_wdata  out  16  store data
- mem_busy  in  1  memory cannot accept a request this cycle
- mem_done  in  1  access complete (read data valid), single-cycle pulse
- mem_rdata  in  16  read data
- Stall_Out  out  1  hold PC/IF/ID/EX/MEM registers
- WBData_ToWB  out  16  writeback data
- WR_ToWB  out  3  destination register
- WriteToReg_ToWB  out  1  register write enable
- Halt_ToWB  out  1  halt
- Valid_ToWB  out  1  MEM/WB holds a real instruction
- Err_ToWB  out  1  sticky memory error

## Operation
- States: IDLE, ISSUE, WAIT, HALTED, ERROR.
- IDLE, no memory op: pass ALUResult to WBData and copy WR/WriteToReg/Halt into MEM/WB at the next edge. Valid=1, Stall_Out=0.
- IDLE with a memory op: transition to ISSUE combinationally in the same cycle. mem_req=1, Stall_Out=1, and MEM/WB loads a bubble (Valid=0, WriteToReg=0, Halt=0).
- ISSUE: mem_req=1, mem_addr=ALUResult, mem_wr=MemWriteEn, mem_wdata=RD2. If mem_busy=0 the request is accepted and the FSM moves to WAIT with the timeout counter cleared. Otherwise it stays in ISSUE with Stall_Out=1.
- WAIT: mem_req=0 and Stall_Out=1 until mem_done. In the mem_done cycle:
  - Stall_Out=0.
  - MEM/WB loads WBData = RegWriteDataSel ? mem_rdata : ALUResult, plus WR/WriteToReg/Halt, with Valid=1.
  - The FSM returns to IDLE. EX/MEM advances on the same edge.
- mem_done outside WAIT is ignored.
- MemReadEn and MemWriteEn both high: no request is issued. Err=1, MEM/WB loads a bubble with Err set, FSM goes to ERROR.
- Timeout: if the WAIT counter reaches TIMEOUT_CYC without mem_done, the FSM goes to ERROR, Err=1, and MEM/WB loads a bubble.
- A halt passing through MEM/WB (Halt=1, Valid=1) moves the FSM to HALTED. HALTED and ERROR are absorbing:
  - Stall_Out=1, no requests, MEM/WB holds bubbles.
  - Err remains as set. Only rst exits.
- Flags Z/N/Ofl/Cout are not consumed by this block.

## Timing
- Reset values: all MEM/WB outputs 0, Stall_Out=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, state IDLE, counter 0.
- Reset asserted mid-access abandons the access. mem_req drops asynchronously.
- Non-memory instruction: 1-cycle latency EX/MEM to MEM/WB.
- Memory instruction: 1 issue cycle, plus busy cycles, plus cycles up to and including mem_done. With mem_busy=0 and mem_done two cycles after acceptance, Stall_Out is high for 2 cycles.
- mem_req, mem_addr, mem_wr and mem_wdata are stable from first assertion until accepted.
- Timeout counter is 8 bits and saturates, with no wrap.

## Configuration
- MEMSTG_ALIGN_CHECK_EN defined: a memory op with ALUResult[0]=1 issues no request. Err=1, bubble, FSM goes to ERROR in the same cycle.
- MEMSTG_ALIGN_CHECK_EN not defined: no alignment check. The address is passed unmodified, including bit 0.

## Structure
- Shared package (mem_stage_pkg): state encoding constants, default TIMEOUT_CYC, MEM/WB bundle width constants.
- One sub-module, memwb_reg: MEM/WB register with asynchronous reset and bubble-load input. The FSM, counter and request logic stay in mem_stage_ctrl.

## Test plan
- ADD result 0x1234, WR=3, WriteToReg=1 → next cycle WBData=0x1234, WR_ToWB=3, Valid=1, Stall_Out never high.
- Load at 0x0040 with mem_busy=0 and mem_done plus mem_rdata=0xBEEF 2 cycles after acceptance → Stall_Out high 2 cycles, then WBData=0xBEEF, Valid=1.
- Store at 0x0010, data 0x00FF, with mem_busy held 3 cycles → mem_req held 4 cycles with a constant address; MEM/WB Valid=1, WriteToReg=0 after mem_done.
- Load with no mem_done and TIMEOUT_CYC=4 → Err_ToWB=1 after 4 WAIT cycles, Stall_Out stuck at 1, recovery only via rst.
- Halt instruction → Halt_ToWB=1; the following load issues no mem_req, Stall_Out=1.
- Load at 0x0041 with MEMSTG_ALIGN_CHECK_EN defined → no mem_req, Err=1. Without the macro → mem_addr=0x0041, normal completion.
